// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 LED path.
//   state_t       : refresh scheduler FSM encoding
//   DEF_*         : default timing for a 100 MHz clock
//   G_/R_/B_ HI/LO: byte slices of a {G,R,B} frame word (shared with the parser)
//   cw()          : counter width for a count range of n (never below 1)
package ws2812_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_LOAD, ST_SHIFT, ST_LATCH} state_t;

  localparam int WORD_W          = 24;
  localparam int DEF_ADDR_W      = 11;
  localparam int DEF_BIT_CYC     = 125;
  localparam int DEF_T0H_CYC     = 40;
  localparam int DEF_T1H_CYC     = 80;
  localparam int DEF_RESET_CYC   = 30000;
  localparam int DEF_REFRESH_CYC = 1666667;

  localparam int G_HI = 23, G_LO = 16;
  localparam int R_HI = 15, R_LO = 8;
  localparam int B_HI = 7,  B_LO = 0;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ws2812_frame_sched_if.sv
// Frame RAM read port.
//   mem_rd_en   : single-cycle read strobe
//   mem_rd_addr : pixel address
//   mem_rd_data : {G,R,B} word, valid the cycle after mem_rd_en
// master = scheduler side, slave = RAM side.
interface ws2812_frame_sched_if #(parameter int ADDR_W = 11);
  import ws2812_pkg::*;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [WORD_W-1:0] mem_rd_data;

  modport master (output mem_rd_en, mem_rd_addr, input mem_rd_data);
  modport slave  (input mem_rd_en, mem_rd_addr, output mem_rd_data);
endinterface

// File: rtl/ws2812_bit_tx.sv
// WS2812 bit serialiser for one 24-bit word, MSB first.
//   load       : start a word next cycle (bit 23, cycle 0); may coincide with
//                word_done to chain words back to back
//   word       : {G,R,B} word captured on load
//   dout       : line level, high for T1H/T0H cycles of each BIT_CYC period
//   word_start : cycle 0 of bit 23
//   bit_last   : last cycle of any bit
//   word_done  : last cycle of bit 0
module ws2812_bit_tx
  import ws2812_pkg::*;
#(
  parameter int BIT_CYC = DEF_BIT_CYC,
  parameter int T0H_CYC = DEF_T0H_CYC,
  parameter int T1H_CYC = DEF_T1H_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  output logic              dout,
  output logic              word_start,
  output logic              bit_last,
  output logic              word_done
);
  localparam int CW = cw(BIT_CYC);

  logic [WORD_W-1:0] sh;
  logic [4:0]        bit_idx;
  logic [CW-1:0]     c;
  logic              active;

  assign bit_last   = active && (c == CW'(BIT_CYC - 1));
  assign word_done  = bit_last && (bit_idx == 5'd0);
  assign word_start = active && (c == '0) && (bit_idx == 5'd23);
  // Purely combinational from flops so an async reset drops the line at once.
  assign dout = active && (sh[WORD_W-1] ? (c < CW'(T1H_CYC)) : (c < CW'(T0H_CYC)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh      <= '0;
      bit_idx <= '0;
      c       <= '0;
      active  <= 1'b0;
    end else if (load) begin
      sh      <= word;
      bit_idx <= 5'd23;
      c       <= '0;
      active  <= 1'b1;
    end else if (active) begin
      if (bit_last) begin
        c  <= '0;
        sh <= {sh[WORD_W-2:0], 1'b0};
        if (bit_idx == 5'd0) active  <= 1'b0;
        else                 bit_idx <= bit_idx - 5'd1;
      end else begin
        c <= c + 1'b1;
      end
    end
  end
endmodule

// File: rtl/ws2812_frame_sched.sv
// WS2812 frame refresh scheduler. On a trigger (dirty flag or refresh timer)
// reads pixels 0..n-1 from the frame RAM, serialises them with no gap between
// pixels, then holds the line low for the latch period.
//   clk, rst_n : clock, async active-low reset
//   num_leds   : LED count, sampled at frame start (clamped to 2^ADDR_W)
//   wr_strobe  : parser write pulse, marks the frame dirty
//   mem        : frame RAM read port (master)
//   dout       : WS2812 data line
//   busy       : high from FETCH through the last LATCH cycle
//   frame_done : pulse on the last LATCH cycle
module ws2812_frame_sched
  import ws2812_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int BIT_CYC     = DEF_BIT_CYC,
  parameter int T0H_CYC     = DEF_T0H_CYC,
  parameter int T1H_CYC     = DEF_T1H_CYC,
  parameter int RESET_CYC   = DEF_RESET_CYC,
  parameter int REFRESH_CYC = DEF_REFRESH_CYC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [11:0]          num_leds,
  input  logic                 wr_strobe,
  ws2812_frame_sched_if.master mem,
  output logic                 dout,
  output logic                 busy,
  output logic                 frame_done
);
  localparam int NW = ADDR_W + 1;
  localparam int LW = cw(RESET_CYC);
  localparam logic [NW-1:0] MAX_N = {1'b1, {ADDR_W{1'b0}}};

  if (!(T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC && BIT_CYC >= 4)) begin : g_bad_params
    $error("ws2812_frame_sched: need T0H_CYC < T1H_CYC < BIT_CYC and BIT_CYC >= 4");
  end

  state_t            state, nstate;
  logic              dirty, ref_trig, start;
  logic [NW-1:0]     n_q, n_clamp, pix_idx, next_pix;
  logic              more, pf_pend;
  logic [WORD_W-1:0] next_reg, tx_word;
  logic [LW-1:0]     lat_cnt;
  logic              tx_load, tx_word_start, tx_bit_last, tx_word_done;

  assign n_clamp  = (32'(num_leds) > 32'(MAX_N)) ? MAX_N : NW'(num_leds);
  assign start    = (state == ST_IDLE) && (dirty || ref_trig);
  assign next_pix = pix_idx + 1'b1;
  assign more     = next_pix < n_q;
  assign busy     = (state != ST_IDLE);

  // Refresh timer: free-runs only while idle and restarts whenever it fires.
  if (REFRESH_CYC > 0) begin : g_ref
    localparam int RW = cw(REFRESH_CYC);
    logic [RW-1:0] ref_cnt;
    assign ref_trig = (state == ST_IDLE) && (ref_cnt == RW'(REFRESH_CYC - 1));
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            ref_cnt <= '0;
      else if (state != ST_IDLE || ref_trig) ref_cnt <= '0;
      else                                   ref_cnt <= ref_cnt + 1'b1;
    end
  end else begin : g_noref
    assign ref_trig = 1'b0;
  end

  ws2812_bit_tx #(.BIT_CYC(BIT_CYC), .T0H_CYC(T0H_CYC), .T1H_CYC(T1H_CYC)) u_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tx_load),
    .word       (tx_word),
    .dout       (dout),
    .word_start (tx_word_start),
    .bit_last   (tx_bit_last),
    .word_done  (tx_word_done)
  );

  always_comb begin
    nstate          = state;
    mem.mem_rd_en   = 1'b0;
    mem.mem_rd_addr = '0;
    tx_load         = 1'b0;
    tx_word         = next_reg;
    frame_done      = 1'b0;
    case (state)
      ST_IDLE:  if (start && n_clamp != '0) nstate = ST_FETCH;
      ST_FETCH: begin
        mem.mem_rd_en = 1'b1;
        nstate        = ST_LOAD;
      end
      ST_LOAD: begin
        tx_load = 1'b1;
        tx_word = mem.mem_rd_data;
        nstate  = ST_SHIFT;
      end
      ST_SHIFT: begin
        // Prefetch the next pixel a whole word ahead of when it is needed.
        if (tx_word_start && more) begin
          mem.mem_rd_en   = 1'b1;
          mem.mem_rd_addr = next_pix[ADDR_W-1:0];
        end
        if (tx_bit_last && tx_word_done) begin
          if (more) tx_load = 1'b1;
          else      nstate  = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (lat_cnt == LW'(RESET_CYC - 1)) begin
          frame_done = 1'b1;
          nstate     = ST_IDLE;
        end
      end
      default: nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      dirty    <= 1'b0;
      n_q      <= '0;
      pix_idx  <= '0;
      pf_pend  <= 1'b0;
      next_reg <= '0;
      lat_cnt  <= '0;
    end else begin
      state <= nstate;
      // A strobe coinciding with the start keeps the flag for the next frame.
      if (start)          dirty <= wr_strobe;
      else if (wr_strobe) dirty <= 1'b1;
      if (start) n_q <= n_clamp;
      if (state == ST_LOAD)
        pix_idx <= '0;
      else if (state == ST_SHIFT && tx_word_done && more)
        pix_idx <= next_pix;
      pf_pend <= (state == ST_SHIFT) && tx_word_start && more;
      if (pf_pend) next_reg <= mem.mem_rd_data;
      if (state != ST_LATCH) lat_cnt <= '0;
      else                   lat_cnt <= lat_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Scoreboard bench for ws2812_frame_sched. Instance A (no auto-refresh) is driven
// with directed and random frames; instance B (REFRESH_CYC=100) free-runs.
module tb_ws2812_frame_sched;
  localparam int AW = 11, BC = 10, T0 = 3, T1 = 7, RC = 50, RP = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst_n_b, wr_strobe, wr_strobe_b;
  logic [11:0] num_leds, num_leds_b;
  logic        dout, busy, frame_done, dout_b, busy_b, fd_b;

  ws2812_frame_sched_if #(.ADDR_W(AW)) mem_a ();
  ws2812_frame_sched_if #(.ADDR_W(AW)) mem_b ();

  ws2812_frame_sched #(.ADDR_W(AW), .BIT_CYC(BC), .T0H_CYC(T0), .T1H_CYC(T1),
                       .RESET_CYC(RC), .REFRESH_CYC(0)) dut (
    .clk(clk), .rst_n(rst_n), .num_leds(num_leds), .wr_strobe(wr_strobe),
    .mem(mem_a), .dout(dout), .busy(busy), .frame_done(frame_done));

  ws2812_frame_sched #(.ADDR_W(AW), .BIT_CYC(BC), .T0H_CYC(T0), .T1H_CYC(T1),
                       .RESET_CYC(RC), .REFRESH_CYC(RP)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .num_leds(num_leds_b), .wr_strobe(wr_strobe_b),
    .mem(mem_b), .dout(dout_b), .busy(busy_b), .frame_done(fd_b));

  // Frame RAM model: registered read, data valid the cycle after the strobe.
  logic [23:0] ram [0:2047];
  always @(posedge clk) begin
    if (mem_a.mem_rd_en) mem_a.mem_rd_data <= ram[mem_a.mem_rd_addr];
    if (mem_b.mem_rd_en) mem_b.mem_rd_data <= ram[mem_b.mem_rd_addr];
  end

  int tests = 0, fails = 0;
  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Scoreboard queues, filled from the reference model when a frame is requested.
  int exp_w[$], exp_len[$], exp_addr[$];
  int gaps_b[$];

  // Reference: each pixel p is read once (addr p), each bit b of its word
  // gives one high pulse of T1 or T0 cycles, and the frame is busy for
  // FETCH + LOAD + 24*n bit periods + the latch period.
  task automatic push_frame(input int n);
    logic [23:0] w;
    for (int p = 0; p < n; p++) begin
      exp_addr.push_back(p);
      w = ram[p];
      for (int b = 23; b >= 0; b--) exp_w.push_back(w[b] ? T1 : T0);
    end
    exp_len.push_back(2 + 24 * n * BC + RC);
  endtask

  // Monitor A: pops the scoreboard whenever the DUT completes a pulse, a
  // frame or a RAM read.
  int  fd_cnt = 0, rd_cnt = 0, last_gap = -1;
  initial begin
    int hw, bw, gap;
    logic pd, pb, pfd;
    hw = 0; bw = 0; gap = 0; pd = 0; pb = 0; pfd = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hw = 0; bw = 0; gap = 0; pd = 0; pb = 0; pfd = 0;
      end else begin
        if (dout) hw++;
        else if (pd) begin
          if (exp_w.size() == 0) check("unexpected_pulse", hw, 0);
          else check("high_width", hw, exp_w.pop_front());
          hw = 0;
        end
        pd = dout;
        if (busy) begin
          if (!pb) last_gap = gap;
          bw++; gap = 0;
        end else begin
          if (pb) begin
            if (exp_len.size() == 0) check("unexpected_frame", bw, 0);
            else check("frame_len", bw, exp_len.pop_front());
            check("done_on_last_busy", pfd, 1);
            bw = 0;
          end
          gap++;
        end
        pb = busy;
        pfd = frame_done;
        if (frame_done) fd_cnt++;
        if (mem_a.mem_rd_en) begin
          rd_cnt++;
          if (exp_addr.size() == 0) check("unexpected_read", 1, 0);
          else check("rd_addr", mem_a.mem_rd_addr, exp_addr.pop_front());
        end
      end
    end
  end

  // Monitor B: auto-refresh instance, one LED, no strobes.
  initial begin
    int bw, gap;
    logic pb, pfd;
    bw = 0; gap = 0; pb = 0; pfd = 0;
    forever begin
      @(negedge clk);
      if (!rst_n_b) begin
        bw = 0; gap = 0; pb = 0; pfd = 0;
      end else begin
        if (busy_b) begin
          if (!pb) gaps_b.push_back(gap);
          bw++; gap = 0;
        end else begin
          if (pb) begin
            check("b_frame_len", bw, 2 + 24 * BC + RC);
            check("b_done_on_last_busy", pfd, 1);
            bw = 0;
          end
          gap++;
        end
        pb = busy_b;
        pfd = fd_b;
      end
    end
  end

  task automatic strobe();
    @(negedge clk) wr_strobe = 1'b1;
    @(negedge clk) wr_strobe = 1'b0;
  endtask

  task automatic wait_frames(input int k, input int maxc, input string name);
    int f0 = fd_cnt - k;  // caller passes k relative to a snapshot below
    int c = 0;
    f0 = fd_cnt;
    while (fd_cnt < f0 + k && c < maxc) begin
      @(negedge clk);
      c++;
    end
    if (fd_cnt < f0 + k) check({name, "_timeout"}, c, -1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_frame(input int n, input string name);
    num_leds = 12'(n);
    push_frame(n);
    strobe();
    wait_frames(1, 24 * n * BC + RC + 100, name);
    check({name, "_sb_drained"}, exp_w.size() + exp_len.size() + exp_addr.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int f0, r0, bc, dc, rises, n;
    logic pdv, dout_pre;
    rst_n = 0; rst_n_b = 0; wr_strobe = 0; wr_strobe_b = 0;
    num_leds = 0; num_leds_b = 12'd1;
    for (int i = 0; i < 2048; i++) ram[i] = 24'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_rd_en", mem_a.mem_rd_en, 0);
    check("rst_rd_addr", mem_a.mem_rd_addr, 0);
    @(negedge clk) begin rst_n = 1; rst_n_b = 1; end
    repeat (5) @(negedge clk);

    // 1: single LED, known pattern
    ram[0] = 24'hA50000;
    f0 = fd_cnt;
    run_frame(1, "t1");
    check("t1_frame_done_count", fd_cnt - f0, 1);

    // 2: three LEDs back to back, three reads
    ram[0] = 24'hFFFFFF; ram[1] = 24'h000000; ram[2] = 24'h0F0F0F;
    r0 = rd_cnt;
    run_frame(3, "t2");
    check("t2_read_count", rd_cnt - r0, 3);

    // random frames
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 4);
      for (int p = 0; p < n; p++) ram[p] = 24'($urandom);
      run_frame(n, "rand");
    end

    // 3: strobe mid-SHIFT queues exactly one more frame
    num_leds = 12'd2;
    push_frame(2);
    push_frame(2);
    strobe();
    repeat (100) @(negedge clk);
    strobe();
    num_leds = 12'd1;  // not seen until the re-triggered frame... which already latched 2? no: see below
    num_leds = 12'd2;
    wait_frames(2, 2000, "t3");
    check("t3_gap_between_frames", last_gap, 1);
    check("t3_sb_drained", exp_w.size() + exp_len.size() + exp_addr.size(), 0);
    bc = 0;
    repeat (40) @(negedge clk) if (busy) bc++;
    check("t3_no_third_frame", bc, 0);

    // 4: zero LEDs: nothing happens, dirty is dropped
    f0 = fd_cnt; r0 = rd_cnt;
    num_leds = 12'd0;
    strobe();
    bc = 0; dc = 0;
    repeat (30) @(negedge clk) begin
      if (busy) bc++;
      if (dout) dc++;
    end
    check("t4_busy", bc, 0);
    check("t4_dout", dc, 0);
    check("t4_frame_done", fd_cnt - f0, 0);
    check("t4_reads", rd_cnt - r0, 0);
    num_leds = 12'd1;
    bc = 0;
    repeat (30) @(negedge clk) if (busy) bc++;
    check("t4_dirty_cleared", bc, 0);

    // 6: async reset during bit 5
    ram[0] = 24'hFFFFFF;
    num_leds = 12'd1;
    push_frame(1);
    strobe();
    rises = 0; pdv = 0;
    for (int c = 0; c < 400 && rises < 6; c++) begin
      @(negedge clk);
      if (dout && !pdv) rises++;
      pdv = dout;
    end
    check("t6_reached_bit5", rises, 6);
    #2;
    dout_pre = dout;
    rst_n = 0;
    #1;
    check("t6_dout_high_before", dout_pre, 1);
    check("t6_dout_async", dout, 0);
    check("t6_busy_async", busy, 0);
    check("t6_rd_en_async", mem_a.mem_rd_en, 0);
    exp_w.delete(); exp_len.delete(); exp_addr.delete();
    repeat (3) @(negedge clk);
    rst_n = 1;
    bc = 0;
    repeat (40) @(negedge clk) if (busy) bc++;
    check("t6_idle_after_reset", bc, 0);
    ram[0] = 24'($urandom);
    run_frame(1, "t6_recover");

    // 5: auto-refresh instance spacing
    check("t5_frames_seen", gaps_b.size() >= 3, 1);
    for (int i = 1; i < gaps_b.size(); i++) check("t5_refresh_gap", gaps_b[i], RP);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
